// File: rtl/scene_sequencer_if.sv
// Pixel/control bundle between the video timing, the image generators and the
// scene sequencer. master drives frame/visible/sources/buttons; slave drives the pins.
interface scene_sequencer_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_SRC)
);
    logic [31:0]           frame;
    logic                  visible;
    logic [NUM_SRC*12-1:0] src_rgb;
    logic                  next_req;
    logic                  hold;
    logic [3:0]            r;
    logic [3:0]            g;
    logic [3:0]            b;
    logic [SRC_W-1:0]      active_src;
    logic [NUM_SRC-1:0]    src_frame_en;
    logic                  busy;

    modport master (
        output frame, visible, src_rgb, next_req, hold,
        input  r, g, b, active_src, src_frame_en, busy
    );

    modport slave (
        input  frame, visible, src_rgb, next_req, hold,
        output r, g, b, active_src, src_frame_en, busy
    );
endinterface

// File: rtl/scene_sequencer.sv
// Shares one RGB output between NUM_SRC generators: dwell on a source, then
// fade out, switch at black, fade back in. Level moves only on frame ticks.
module scene_sequencer #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DWELL_FRAMES = 600,
    parameter int unsigned SRC_W        = $clog2(NUM_SRC)
) (
    input  logic              clk,
    input  logic              rst,
    scene_sequencer_if.slave  bus
);
    localparam int unsigned DW_W = $clog2(DWELL_FRAMES + 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
    localparam logic [SRC_W-1:0] SRC_LAST   = SRC_W'(NUM_SRC - 1);
    localparam logic [4:0]       LVL_MAX    = 5'd16;

    typedef enum logic [1:0] {
        SHOW,
        FADE_OUT,
        SWITCH,
        FADE_IN
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       level_q, level_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             pending_q, pending_d;
    logic [31:0]      frame_prev_q;
    logic             tick;

    // frame_prev resets to the value frame holds during reset, so release gives no tick
    assign tick = (bus.frame != frame_prev_q) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FADE_IN;
            level_q      <= '0;
            src_q        <= '0;
            dwell_q      <= '0;
            pending_q    <= 1'b0;
            frame_prev_q <= '1;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            src_q        <= src_d;
            dwell_q      <= dwell_d;
            pending_q    <= pending_d;
            frame_prev_q <= bus.frame;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        src_d     = src_q;
        dwell_d   = dwell_q;
        pending_d = pending_q;
        unique case (state_q)
            SHOW: begin
                level_d = LVL_MAX;
                if (bus.next_req) begin
                    pending_d = 1'b1;
                end
                // request and expiry share one exit, so coincident events advance once
                if (pending_q || bus.next_req ||
                    (tick && !bus.hold && dwell_q == DWELL_LAST)) begin
                    state_d   = FADE_OUT;
                    pending_d = 1'b0;
                end else if (tick && !bus.hold) begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            FADE_OUT: begin
                if (tick) begin
                    if (level_q == 5'd1) begin
                        level_d = '0;
                        state_d = SWITCH;
                    end else begin
                        level_d = level_q - 1'b1;
                    end
                end
            end
            SWITCH: begin
                src_d   = (src_q == SRC_LAST) ? '0 : src_q + 1'b1;
                dwell_d = '0;
                state_d = FADE_IN;
            end
            FADE_IN: begin
                if (tick) begin
                    level_d = level_q + 1'b1;
                    if (level_q + 1'b1 == LVL_MAX) begin
                        state_d = SHOW;
                    end
                end
            end
            default: state_d = FADE_IN;
        endcase
    end

    logic [11:0]        chan;
    logic [NUM_SRC-1:0] en;

    assign chan = bus.src_rgb[12*src_q +: 12];

    always_comb begin
        en        = '0;
        en[src_q] = 1'b1;
    end

    // channel * level is 9 bits; bits [7:4] give level 16 = unity, level 0 = black
    assign bus.r = bus.visible ? 4'((9'(chan[11:8]) * 9'(level_q)) >> 4) : '0;
    assign bus.g = bus.visible ? 4'((9'(chan[7:4])  * 9'(level_q)) >> 4) : '0;
    assign bus.b = bus.visible ? 4'((9'(chan[3:0])  * 9'(level_q)) >> 4) : '0;

    assign bus.active_src   = src_q;
    assign bus.src_frame_en = en;
    assign bus.busy         = (state_q != SHOW);
endmodule

// File: tb/tb_scene_sequencer.sv
// Scoreboard bench for scene_sequencer: a behavioural model predicts the pins
// each cycle; a negedge monitor pops and compares.
module tb_scene_sequencer;
    localparam int NSRC  = 4;
    localparam int DWELL = 4;
    localparam int CPF   = 3;

    localparam int M_SHOW = 0;
    localparam int M_FO   = 1;
    localparam int M_SW   = 2;
    localparam int M_FI   = 3;

    typedef struct {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic [1:0] src;
        logic [3:0] en;
        logic       busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    scene_sequencer_if #(.NUM_SRC(NSRC)) bus ();

    scene_sequencer #(.NUM_SRC(NSRC), .DWELL_FRAMES(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];
    int   exp_seq[$];
    int   obs_seq[$];

    int          m_state = M_FI;
    int          m_level = 0;
    int          m_src   = 0;
    int          m_dwell = 0;
    logic [31:0] m_fprev = '1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [3:0] scaled(input int c);
        return 4'((c * m_level) / 16);
    endfunction

    task automatic push_expected();
        exp_t e;
        int   px;
        px = int'((bus.src_rgb >> (12 * m_src)) & 48'hFFF);
        e.r    = bus.visible ? scaled((px >> 8) & 15) : 4'h0;
        e.g    = bus.visible ? scaled((px >> 4) & 15) : 4'h0;
        e.b    = bus.visible ? scaled(px & 15) : 4'h0;
        e.src  = 2'(m_src);
        e.en   = 4'(1 << m_src);
        e.busy = (m_state != M_SHOW);
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        bit tk;
        if (rst) begin
            if (m_src != 0) exp_seq.push_back(0);
            m_state = M_FI; m_level = 0; m_src = 0; m_dwell = 0; m_fprev = '1;
            return;
        end
        tk = (bus.frame != m_fprev);
        m_fprev = bus.frame;
        case (m_state)
            M_SHOW: begin
                if (bus.next_req || (tk && !bus.hold && m_dwell == DWELL - 1))
                    m_state = M_FO;
                else if (tk && !bus.hold)
                    m_dwell++;
            end
            M_FO: if (tk) begin
                m_level--;
                if (m_level == 0) m_state = M_SW;
            end
            M_SW: begin
                m_src = (m_src + 1) % NSRC;
                exp_seq.push_back(m_src);
                m_dwell = 0;
                m_state = M_FI;
            end
            default: if (tk) begin
                m_level++;
                if (m_level == 16) m_state = M_SHOW;
            end
        endcase
    endtask

    task automatic cycle();
        push_expected();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            bus.frame = bus.frame + 1;
            repeat (CPF) cycle();
        end
    endtask

    logic [1:0] last_src = '0;

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("r",    bus.r,            e.r);
            check("g",    bus.g,            e.g);
            check("b",    bus.b,            e.b);
            check("src",  bus.active_src,   e.src);
            check("en",   bus.src_frame_en, e.en);
            check("busy", bus.busy,         e.busy);
        end
        if (bus.active_src != last_src) begin
            obs_seq.push_back(int'(bus.active_src));
            last_src = bus.active_src;
        end
    end

    initial begin
        bit found;
        rst          = 1'b1;
        bus.frame    = '1;
        bus.visible  = 1'b1;
        bus.src_rgb  = {12'hF0F, 12'h3C7, 12'h8A5, 12'hFFF};
        bus.next_req = 1'b0;
        bus.hold     = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        repeat (2) cycle();
        check("rst_r",    bus.r,            4'h0);
        check("rst_busy", bus.busy,         1'b1);
        check("rst_en",   bus.src_frame_en, 4'b0001);

        // release with frame still all-ones: no tick, level stays 0
        rst = 1'b0;
        repeat (2) cycle();
        check("rel_busy", bus.busy, 1'b1);

        frames(15);
        check("fade_in_l15_r", bus.r, 4'hE);
        frames(1);
        check("show_busy", bus.busy, 1'b0);
        check("show_r",    bus.r,    4'hF);

        // request mid-dwell leaves at once; a second request during the fade is dropped
        frames(2);
        bus.next_req = 1'b1;
        cycle();
        bus.next_req = 1'b0;
        check("req_busy", bus.busy, 1'b1);
        frames(5);
        bus.next_req = 1'b1;
        cycle();
        bus.next_req = 1'b0;
        frames(27);
        check("req_show", bus.busy,       1'b0);
        check("req_src",  bus.active_src, 2'd1);
        frames(1);
        check("req_once", bus.busy, 1'b0);

        // hold freezes dwell (one tick already counted above)
        bus.hold = 1'b1;
        frames(10);
        check("hold_show", bus.busy, 1'b0);
        bus.hold = 1'b0;
        frames(2);
        check("hold_rem", bus.busy, 1'b0);
        frames(1);
        check("hold_exp", bus.busy, 1'b1);

        bus.visible = 1'b0;
        frames(3);
        check("blank_r", bus.r, 4'h0);
        check("blank_g", bus.g, 4'h0);
        check("blank_b", bus.b, 4'h0);
        bus.visible = 1'b1;

        frames(150);

        // reset mid-fade: reach FADE_OUT of source 2 at level 7
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (m_state == M_SHOW && m_src == 2) begin
                found = 1'b1;
                break;
            end
            frames(1);
        end
        check("find_src2", found, 1'b1);
        bus.next_req = 1'b1;
        cycle();
        bus.next_req = 1'b0;
        frames(9);
        check("fo7_src", bus.active_src, 2'd2);
        check("fo7_r",   bus.r,          4'h1);
        rst       = 1'b1;
        bus.frame = '1;
        cycle();
        check("mid_rst_src",  bus.active_src, 2'd0);
        check("mid_rst_busy", bus.busy,       1'b1);
        check("mid_rst_r",    bus.r,          4'h0);
        rst = 1'b0;
        repeat (2) cycle();
        check("mid_rel_r", bus.r, 4'h0);
        frames(16);
        check("mid_show", bus.busy, 1'b0);
        check("mid_r",    bus.r,    4'hF);

        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        check("seq_len", obs_seq.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < obs_seq.size(); i++)
            check("seq", obs_seq[i], exp_seq[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Frame-synchronous controller that shares the single VGA RGB output between NUM_SRC image generators.
- Shows one source at a time for a dwell period, then cross-sequences to the next source: fade-out, switch, fade-in.
- Sits between the image generators and the top-level r/g/b pins, clocked by the pixel clock.
- Takes the frame counter and the visible flag from video_timer.

Parameters:
- NUM_SRC, 4: number of image sources; ≥2.
- DWELL_FRAMES, 600: full-brightness frames per source before auto-advance; ≥1.
- SRC_W, $clog2(NUM_SRC): width of the source index.

Ports:
- clk  in  1  pixel clock, 25.175 MHz.
- rst  in  1  reset, synchronous, active-high.
- frame  in  32  frame counter from video_timer; holds all-ones during reset, then increments once per frame.
- visible  in  1  active-video flag from video_timer.
- src_rgb  in  NUM_SRC*12  per-source {r,g,b} at 4b each; source i occupies bits [12i+11:12i], with r in the top nibble.
- next_req  in  1  single-cycle advance request (button, already debounced).
- hold  in  1  level; while 1, the dwell counter freezes.
- r  out  4  red to the pins.
- g  out  4  green to the pins.
- b  out  4  blue to the pins.
- active_src  out  SRC_W  index of the source currently routed.
- src_frame_en  out  NUM_SRC  one-hot of active_src; gates each generator's animation update.
- busy  out  1  high in FADE_OUT, SWITCH and FADE_IN.

Behaviour:
- Frame tick:
  - frame_prev is a 32b register, reset to 32'hFFFF_FFFF.
  - tick = (frame != frame_prev) && !rst; frame_prev <= frame every cycle.
  - Result: exactly one tick per frame increment, and none at reset release.
- Level:
  - 5b register, range 0..16.
  - Pixel path is combinational, zero latency: each channel out = visible ? (chan[active_src] * level) >> 4 : 0.
  - The product is 9b; the output is bits [7:4]. Level 16 passes the source through unchanged; level 0 gives black.
- FSM states: SHOW, FADE_OUT, SWITCH, FADE_IN.
  - Reset values: state FADE_IN, level 0, active_src 0, dwell 0, pending 0.
  - Outputs at reset: r/g/b = 0, busy = 1, src_frame_en = 1 (one-hot bit 0).
- pending flag:
  - Set by next_req in SHOW only. next_req in any other state is dropped.
  - Cleared on entering FADE_OUT.
- SHOW:
  - level = 16.
  - On each tick with hold=0: dwell += 1 (width $clog2(DWELL_FRAMES+1)).
  - Go to FADE_OUT when either:
    - pending=1, or next_req is high this cycle; or
    - tick && !hold && dwell == DWELL_FRAMES-1.
  - Simultaneous request and expiry produce a single advance.
- FADE_OUT:
  - On each tick, level -= 1.
  - When level would become 0 (the tick at level 1), set level 0 and go to SWITCH.
  - Duration: 16 ticks.
- SWITCH:
  - Lasts exactly one clk cycle.
  - active_src <= (active_src == NUM_SRC-1) ? 0 : active_src+1; dwell <= 0; go to FADE_IN.
- FADE_IN:
  - On each tick, level += 1.
  - On reaching 16, go to SHOW.
  - Duration: 16 ticks.
- General rules:
  - level never leaves 0..16 and changes only on ticks.
  - active_src changes only in SWITCH, so every source change happens at level 0 (black); no torn colour.
  - hold has no effect on fades.
- Reset mid-operation (any state): all registers return to their reset values on the next edge.

Test Plan:
- Reset, then 16 frames with src0 = 12'hFFF and visible=1 → r/g/b step 0,0,1,2,…,15 (level k gives (15·k)>>4); level 16 is reached after the 16th tick and the state is SHOW.
- DWELL_FRAMES=4, free-running → after reaching SHOW: 4 ticks in SHOW, 16 in FADE_OUT, then SWITCH lasting exactly 1 clk; active_src 0→1 and src_frame_en 4'b0001→4'b0010 while level=0.
- NUM_SRC=4, DWELL_FRAMES=1, run 4 full cycles → active_src sequence 1,2,3,0 (wrap to 0).
- In SHOW at dwell 2 (of 4), pulse next_req → FADE_OUT begins on the next cycle with no wait for a tick; pulse next_req again during the fade → ignored, only one advance.
- In SHOW, hold=1 for 10 frames → dwell frozen, state stays SHOW; release → expiry after the remaining frames. Separately, visible=0 → r=g=b=0 regardless of level.
- Assert rst during FADE_OUT (level 7, active_src 2) → next cycle level 0, active_src 0, FADE_IN, busy=1; no tick on the first cycle after release.
